// File: rtl/rr_mux_4to1.sv
// Four-channel valid/ready merging mux with round-robin arbitration and a single
// registered output slot; SEL1:SEL0 tags each beat with its source channel.
module rr_mux_4to1 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] IN0,
    input  logic [WIDTH-1:0] IN1,
    input  logic [WIDTH-1:0] IN2,
    input  logic [WIDTH-1:0] IN3,
    input  logic             VALID0,
    input  logic             VALID1,
    input  logic             VALID2,
    input  logic             VALID3,
    output logic             READY0,
    output logic             READY1,
    output logic             READY2,
    output logic             READY3,
    output logic [WIDTH-1:0] OUT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             SEL1,
    output logic             SEL0
);

    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;

    logic [WIDTH-1:0] in_arr [4];
    logic [3:0]       valid_vec;
    logic [3:0]       ready_vec;
    logic             load;
    logic             found;
    logic [1:0]       win_idx;
    logic [1:0]       cand;
    logic             xfer;

    assign in_arr[0] = IN0;
    assign in_arr[1] = IN1;
    assign in_arr[2] = IN2;
    assign in_arr[3] = IN3;
    assign valid_vec = {VALID3, VALID2, VALID1, VALID0};

    // Slot can take a new beat when empty or draining this cycle.
    assign load = ~out_valid_q | OUT_READY;

    // Search starts one past the last winner, so the last winner ranks lowest.
    always_comb begin
        found   = 1'b0;
        win_idx = 2'd0;
        cand    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!found && valid_vec[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        ready_vec = 4'b0000;
        if (load && found && !RST) begin
            ready_vec[win_idx] = 1'b1;
        end
    end

    assign xfer = |ready_vec;

    always_comb begin
        out_d       = out_q;
        sel_d       = sel_q;
        last_d      = last_q;
        out_valid_d = out_valid_q & ~OUT_READY;
        if (xfer) begin
            out_d       = in_arr[win_idx];
            sel_d       = win_idx;
            last_d      = win_idx;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sel_q       <= 2'd0;
            last_q      <= 2'd3;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
        end
    end

    assign READY0    = ready_vec[0];
    assign READY1    = ready_vec[1];
    assign READY2    = ready_vec[2];
    assign READY3    = ready_vec[3];
    assign OUT       = out_q;
    assign OUT_VALID = out_valid_q;
    assign SEL1      = sel_q[1];
    assign SEL0      = sel_q[0];

endmodule

// File: tb/tb_rr_mux_4to1.sv
// Bench for rr_mux_4to1: a cycle model predicts grants and pushes expected beats
// into a scoreboard queue that is checked against the registered output.
module tb_rr_mux_4to1;

    logic       clk;
    logic       rst;
    logic [7:0] din [4];
    logic [3:0] valid;
    logic       ready0, ready1, ready2, ready3;
    logic [7:0] dout;
    logic       out_valid;
    logic       out_ready;
    logic       sel1, sel0;

    int checks = 0;
    int errors = 0;

    logic [1:0] m_last  = 2'd3;
    logic       m_valid = 1'b0;
    logic [9:0] m_hold  = '0;
    logic [3:0] m_ready = '0;
    logic [9:0] q [$];

    rr_mux_4to1 #(.WIDTH(8)) dut (
        .CLK      (clk),
        .RST      (rst),
        .IN0      (din[0]),
        .IN1      (din[1]),
        .IN2      (din[2]),
        .IN3      (din[3]),
        .VALID0   (valid[0]),
        .VALID1   (valid[1]),
        .VALID2   (valid[2]),
        .VALID3   (valid[3]),
        .READY0   (ready0),
        .READY1   (ready1),
        .READY2   (ready2),
        .READY3   (ready3),
        .OUT      (dout),
        .OUT_VALID(out_valid),
        .OUT_READY(out_ready),
        .SEL1     (sel1),
        .SEL0     (sel0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Predict this cycle's grant, check outputs, then advance the model to the next edge.
    task automatic model_cycle();
        logic       load, found;
        logic [1:0] widx, cand;
        logic [3:0] er;
        logic [9:0] beat;
        load  = !m_valid || out_ready;
        found = 1'b0;
        widx  = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = m_last + 2'(k);
            if (!found && valid[cand]) begin
                found = 1'b1;
                widx  = cand;
            end
        end
        er = '0;
        if (load && found && !rst) er[widx] = 1'b1;
        check_eq("ready", {28'd0, ready3, ready2, ready1, ready0}, {28'd0, er});
        check_eq("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        beat = {sel1, sel0, dout};
        if (m_valid) begin
            if (q.size() != 0) check_eq("beat", {22'd0, beat}, {22'd0, q[0]});
            else check_eq("beat_count", q.size(), 1);
        end else begin
            check_eq("idle_hold", {22'd0, beat}, {22'd0, m_hold});
        end
        m_ready = er;
        if (rst) begin
            q.delete();
            m_valid = 1'b0;
            m_last  = 2'd3;
            m_hold  = '0;
        end else begin
            if (m_valid && out_ready && q.size() != 0) m_hold = q.pop_front();
            if (found && load) begin
                q.push_back({widx, din[widx]});
                m_last  = widx;
                m_valid = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        valid     = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) din[i] = 8'h00;

        // Reset with every channel requesting
        step();
        step();
        check_eq("rst_out", {24'd0, dout}, 32'd0);
        check_eq("rst_sel", {30'd0, sel1, sel0}, 32'd0);

        // Single request on channel 2
        rst   = 1'b0;
        valid = 4'b0100;
        din[2] = 8'hA5;
        step();
        valid = 4'b0000;
        check_eq("s2_out", {24'd0, dout}, 32'hA5);
        check_eq("s2_sel", {30'd0, sel1, sel0}, 32'd2);
        step();
        step();

        // All channels valid, sustained throughput
        din[0] = 8'h10; din[1] = 8'h21; din[2] = 8'h32; din[3] = 8'h43;
        valid  = 4'b1111;
        for (int i = 0; i < 8; i++) step();
        valid = 4'b0000;
        step();
        step();

        // Load 0x21, then backpressure with channel 3 waiting
        valid = 4'b0010;
        step();
        valid     = 4'b1000;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        out_ready = 1'b1;
        step();
        valid = 4'b0000;
        check_eq("s4_out", {24'd0, dout}, 32'h43);
        step();
        step();

        // last=1, then channels 0 and 3 rise together
        valid = 4'b0010;
        step();
        valid = 4'b1001;
        step();
        check_eq("s5_first", {30'd0, sel1, sel0}, 32'd3);
        valid = 4'b0001;
        step();
        check_eq("s5_second", {30'd0, sel1, sel0}, 32'd0);
        valid = 4'b0000;
        step();
        step();

        // Reset while a beat is held under backpressure
        valid = 4'b0100;
        step();
        valid     = 4'b0000;
        out_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        valid     = 4'b1111;
        step();
        check_eq("s6_sel", {30'd0, sel1, sel0}, 32'd0);
        valid = 4'b0000;
        step();
        step();

        // Random traffic obeying the hold-until-ready source rule
        for (int c = 0; c < 80; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                if (valid[i] && m_ready[i]) valid[i] = 1'b0;
                if (!valid[i] && $urandom_range(0, 1) == 1) begin
                    valid[i] = 1'b1;
                    din[i]   = 8'($urandom);
                end
            end
            step();
        end
        valid     = 4'b0000;
        out_ready = 1'b1;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
